seg7_capture: RTL

//  Reader for the multiplexed 7-segment display bus driven by our hex-to-segment decoder.
//  It samples segment lines plus one-hot digit enables and waits for a stable pattern.
//  It inverts each pattern back to a 4-bit hex value per digit and flags illegal codes.
//  It sits in loopback self-test and bench monitors between the display driver and the checkers.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_to_hex.sv | 21 ++
 rtl/seg7_capture.sv | 111 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment bus reader: the hex segment table,
// the blank code, segment bit positions, and the decoder result type.
package seg7_pkg;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] hex;
  } seg_dec_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup of a segment pattern into its hex value,
// flagging whether the pattern is a legal digit or the blank code.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output seg_dec_t   dec_o
);

  always_comb begin
    dec_o       = '0;
    dec_o.blank = (seg_i == SEG_BLANK);
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg_i == SEG_HEX[i]) begin
        dec_o.legal = 1'b1;
        dec_o.hex   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Captures stable digit patterns from a multiplexed 7-segment bus into a
// per-digit hex register file, with frame completion and error pulses.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg,
  input  logic              dp,
  input  logic [NDIG-1:0]   dig_en,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   dig_valid,
  output logic [NDIG-1:0]   dp_seen,
  output logic              frame_done,
  output logic              bad_pattern,
  output logic              onehot_err
);

  localparam int unsigned    CW      = $clog2(STABLE_CYC);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0]  CNT_PRE = CW'(STABLE_CYC - 2);

  logic [6:0]        prev_seg_q;
  logic [NDIG-1:0]   prev_en_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NDIG-1:0]   mask_q, mask_d;
  logic [4*NDIG-1:0] digits_q, digits_d;
  logic [NDIG-1:0]   valid_q, valid_d;
  logic [NDIG-1:0]   dp_q, dp_d;
  logic              frame_q, frame_d;
  logic              bad_q, bad_d;
  logic              ohe_q, ohe_d;

  logic              en_multi, prev_multi, onehot, same, capture;
  logic [NDIG-1:0]   mask_set;
  seg_dec_t          dec;

  seg7_to_hex u_dec (
    .seg_i (seg),
    .dec_o (dec)
  );

  assign en_multi   = (dig_en & (dig_en - NDIG'(1))) != '0;
  assign prev_multi = (prev_en_q & (prev_en_q - NDIG'(1))) != '0;
  assign onehot     = (dig_en != '0) && !en_multi;
  assign same       = (seg == prev_seg_q) && (dig_en == prev_en_q);
  // Strobe on the single step into the saturated count, so a held pattern captures once.
  assign capture    = onehot && same && (cnt_q == CNT_PRE);

  always_comb begin
    cnt_d    = '0;
    if (onehot && same) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    digits_d = digits_q;
    valid_d  = valid_q;
    dp_d     = dp_q;
    mask_set = mask_q;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (capture && dig_en[k]) begin
        mask_set[k] = 1'b1;
        valid_d[k]  = dec.legal;
        if (dec.legal) begin
          digits_d[4*k +: 4] = dec.hex;
          dp_d[k]            = dp;
        end
      end
    end

    frame_d = &mask_set;
    mask_d  = frame_d ? '0 : mask_set;
    bad_d   = capture && !dec.legal && !dec.blank;
    ohe_d   = en_multi && !prev_multi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_seg_q <= '0;
      prev_en_q  <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      digits_q   <= '0;
      valid_q    <= '0;
      dp_q       <= '0;
      frame_q    <= 1'b0;
      bad_q      <= 1'b0;
      ohe_q      <= 1'b0;
    end else begin
      prev_seg_q <= seg;
      prev_en_q  <= dig_en;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      dp_q       <= dp_d;
      frame_q    <= frame_d;
      bad_q      <= bad_d;
      ohe_q      <= ohe_d;
    end
  end

  assign digits      = digits_q;
  assign dig_valid   = valid_q;
  assign dp_seen     = dp_q;
  assign frame_done  = frame_q;
  assign bad_pattern = bad_q;
  assign onehot_err  = ohe_q;

endmodule
